conv_operand_feeder: RTL and testbench
======================================

Name: conv_operand_feeder

Overview:
Upstream sequencer for mac_datapath. Holds one feature map and one KxK kernel in local register buffers. On start it sweeps every output window and drives the MAC's a/b/en, clearing the accumulator before each window. It flags the cycle in which the MAC's muxer output holds a completed window sum, so a downstream collector can capture it.

Parameters:
DATA_W, 8, operand width (matches MAC a/b)
IMG_W, 4, feature-map width in pixels
IMG_H, 4, feature-map height in pixels
K, 2, kernel edge (window is K*K taps)
STRIDE, 1, window step in both directions
MAC_LAT, 1, cycles from the last tap presented to the sum being visible on muxer

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
load_en  in  1  write strobe for the buffers (honoured only when busy=0)
load_sel  in  1  0 = image buffer, 1 = kernel buffer
load_addr  in  clog2(IMG_W*IMG_H)  row-major write address (kernel uses the low bits)
load_data  in  DATA_W  write data
start  in  1  begin a sweep (honoured only when busy=0)
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at sweep end
a  out  DATA_W  pixel operand to the MAC
b  out  DATA_W  weight operand to the MAC
mac_en  out  1  MAC accumulate enable
mac_clr  out  1  accumulator clear (ORed with system rst into the MAC rst)
sum_valid  out  1  muxer holds the completed window sum this cycle
out_row  out  clog2(OH)  output row of the current window, OH=(IMG_H-K)/STRIDE+1
out_col  out  clog2(OW)  output column of the current window, OW=(IMG_W-K)/STRIDE+1

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, mac_en=0, mac_clr=0, sum_valid=0, a=0, b=0, out_row=0, out_col=0. State goes to IDLE. Buffer contents are not reset.
- States are IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: on load_en, write buffer[load_sel][load_addr]. On start, go to CLEAR, set busy=1, and zero the row, col, kr and kc counters.
- CLEAR (1 cycle): mac_clr=1, mac_en=0, a=b=0. Then go to FEED.
- FEED (K*K cycles): mac_en=1.
  - a = img[(row*STRIDE+kr)*IMG_W + col*STRIDE+kc].
  - b = ker[kr*K+kc].
  - Taps are visited in row-major order: kc increments fastest.
  - After the last tap (kr=kc=K-1), go to DRAIN.
- DRAIN (MAC_LAT cycles): mac_en=0, a=b=0. sum_valid=1 in the final DRAIN cycle only, with out_row/out_col naming the window.
  - Then, if more windows remain, advance col (wrapping col to 0 and incrementing row at OW-1) and go to CLEAR.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=0. Behaves as IDLE for start/load, so back-to-back sweeps are allowed. Then go to IDLE.
- Throughput is 1+K*K+MAC_LAT cycles per window; there are OH*OW windows per sweep.
- start or load_en while busy=1 is ignored; buffers are never modified mid-sweep.
- start and load_en in the same idle cycle: the write happens, and the sweep begins next cycle and sees the new value.
- rst mid-sweep: next cycle is IDLE with all outputs at reset values; no sum_valid or done is produced.
- Width rule: K*K*(2^DATA_W-1)^2 must fit in the MAC's 19-bit accumulator (K=2 gives max 260100). This is checked by an elaboration-time assertion.
- Out-of-range load_addr (≥ IMG_W*IMG_H for the image, ≥ K*K for the kernel) is dropped.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W and ACC_W=19 constants;
  - the feeder state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - an output-dimension function computing OH/OW from size, K and STRIDE.
- One sub-module: conv_window_addr_gen, the nested row/col/kr/kc counters producing the image and kernel addresses plus last_tap and last_window flags. Buffers and the FSM stay in the top module.

Test Plan:
- Load image 1..16 row-major and kernel {1,2,3,4}, start, with the MAC attached. Required sums on sum_valid, in order: 44,54,64,84,94,104,124,134,144. out_row/out_col run (0,0)..(2,2). Exactly 9 sum_valid pulses, then done at cycle 9*6+1 after start.
- Window (0,0) operand trace: (a,b) = (1,1),(2,2),(5,3),(6,4) on four consecutive mac_en=1 cycles. mac_clr=1 on the preceding cycle.
- All buffer entries 255: every sum = 260100, with no overflow on the 19-bit muxer.
- Assert rst in the 2nd FEED cycle of window (1,1): next cycle busy=0 and all outputs 0. A new start without reloading reproduces the first test's sums.
- Pulse start and load_en (image addr 0 = 99) mid-sweep: both are ignored and the sums are unchanged. After done, a load then start gives a first sum of 99*1+2*2+5*3+6*4 = 142.
- Assert start in the done cycle: a second sweep begins with no idle gap and repeats all 9 sums.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, feeder state type and sizing helpers for the convolution
// operand path that feeds mac_datapath.
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feed_state_e;

    // Number of valid window positions along one axis.
    function automatic int out_dim(input int size, input int k, input int stride);
        return (size - k) / stride + 1;
    endfunction

    // Counter width that stays legal for a count of one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Nested window (row/col) and tap (kr/kc) counters; turns the current tap of the
// current window into image and kernel buffer addresses.
module conv_window_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int K      = 2,
    parameter int STRIDE = 1,
    parameter int OH     = 3,
    parameter int OW     = 3,
    parameter int AW     = 4,
    parameter int KAW    = 2,
    parameter int RW     = 2,
    parameter int CW     = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           tap_step_i,
    input  logic           win_step_i,
    output logic [AW-1:0]  img_addr_o,
    output logic [KAW-1:0] ker_addr_o,
    output logic           last_tap_o,
    output logic           last_window_o,
    output logic [RW-1:0]  row_o,
    output logic [CW-1:0]  col_o
);

    localparam int KW = cnt_w(K);

    logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    assign last_tap_o    = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
    assign last_window_o = (row_q == RW'(OH - 1)) && (col_q == CW'(OW - 1));

    assign img_addr_o = AW'((32'(row_q) * STRIDE + 32'(kr_q)) * IMG_W
                            + 32'(col_q) * STRIDE + 32'(kc_q));
    assign ker_addr_o = KAW'(32'(kr_q) * K + 32'(kc_q));

    assign row_o = row_q;
    assign col_o = col_q;

    always_comb begin
        kr_d  = kr_q;
        kc_d  = kc_q;
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            kr_d  = '0;
            kc_d  = '0;
            row_d = '0;
            col_d = '0;
        end else begin
            // Tap counters wrap to zero after the last tap, ready for the next window.
            if (tap_step_i) begin
                if (kc_q == KW'(K - 1)) begin
                    kc_d = '0;
                    kr_d = last_tap_o ? '0 : kr_q + KW'(1);
                end else begin
                    kc_d = kc_q + KW'(1);
                end
            end
            if (win_step_i) begin
                if (col_q == CW'(OW - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kr_q  <= '0;
            kc_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            kr_q  <= kr_d;
            kc_q  <= kc_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/conv_operand_feeder.sv
// Holds one feature map and one KxK kernel, then sweeps every output window
// into the MAC: clear, K*K taps, drain, with sum_valid on the completed sum.
module conv_operand_feeder
    import cnn_pkg::*;
#(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int IMG_W   = 4,
    parameter int IMG_H   = 4,
    parameter int K       = 2,
    parameter int STRIDE  = 1,
    parameter int MAC_LAT = 1,
    localparam int NPIX   = IMG_W * IMG_H,
    localparam int OH     = out_dim(IMG_H, K, STRIDE),
    localparam int OW     = out_dim(IMG_W, K, STRIDE),
    localparam int AW     = cnt_w(NPIX),
    localparam int RW     = cnt_w(OH),
    localparam int CW     = cnt_w(OW)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_en_i,
    input  logic              load_sel_i,
    input  logic [AW-1:0]     load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    output logic              sum_valid_o,
    output logic [RW-1:0]     out_row_o,
    output logic [CW-1:0]     out_col_o
);

    localparam int KAW = cnt_w(K * K);
    localparam int DRW = cnt_w(MAC_LAT);
    localparam longint PIX_MAX = (longint'(1) << DATA_W) - 1;
    localparam longint MAX_SUM = longint'(K * K) * PIX_MAX * PIX_MAX;

    if (MAX_SUM >= (longint'(1) << ACC_W) || MAC_LAT < 1) begin : g_bad_cfg
        $error("conv_operand_feeder: window sum overflows the accumulator or MAC_LAT < 1");
    end

    feed_state_e       state_q, state_d;
    logic [DRW-1:0]    drain_q, drain_d;
    logic              fed_last_q, fed_last_d;
    logic              win_clr, tap_step, win_step;
    logic              last_tap, last_window, idle_like;
    logic [AW-1:0]     img_addr;
    logic [KAW-1:0]    ker_addr;
    logic [DATA_W-1:0] img_mem [NPIX];
    logic [DATA_W-1:0] ker_mem [K*K];

    logic              busy_q, done_q, mac_en_q, mac_clr_q, sum_valid_q;
    logic [DATA_W-1:0] a_q, b_q;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

    conv_window_addr_gen #(
        .IMG_W (IMG_W), .K (K), .STRIDE (STRIDE), .OH (OH), .OW (OW),
        .AW (AW), .KAW (KAW), .RW (RW), .CW (CW)
    ) u_addr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clr_i         (win_clr),
        .tap_step_i    (tap_step),
        .win_step_i    (win_step),
        .img_addr_o    (img_addr),
        .ker_addr_o    (ker_addr),
        .last_tap_o    (last_tap),
        .last_window_o (last_window),
        .row_o         (out_row_o),
        .col_o         (out_col_o)
    );

    // Writes only while idle, so a sweep always sees a stable buffer.
    always_ff @(posedge clk_i) begin
        if (load_en_i && idle_like) begin
            if (!load_sel_i) begin
                if (32'(load_addr_i) < NPIX) img_mem[load_addr_i] <= load_data_i;
            end else if (32'(load_addr_i) < K * K) begin
                ker_mem[KAW'(load_addr_i)] <= load_data_i;
            end
        end
    end

    // tap_step issues the tap the counters point at; fed_last_q remembers that
    // the tap now on a/b is the window's final one.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        fed_last_d = fed_last_q;
        win_clr    = 1'b0;
        tap_step   = 1'b0;
        win_step   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    state_d = ST_CLEAR;
                    win_clr = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d    = ST_FEED;
                tap_step   = 1'b1;
                fed_last_d = last_tap;
            end
            ST_FEED: begin
                if (fed_last_q) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    tap_step   = 1'b1;
                    fed_last_d = last_tap;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRW'(MAC_LAT - 1)) begin
                    if (last_window) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_CLEAR;
                        win_step = 1'b1;
                    end
                end else begin
                    drain_d = drain_q + DRW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            fed_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            fed_last_q  <= fed_last_d;
            busy_q      <= (state_d == ST_CLEAR) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_DONE);
            mac_clr_q   <= (state_d == ST_CLEAR);
            mac_en_q    <= tap_step;
            sum_valid_q <= (state_d == ST_DRAIN) && (drain_d == DRW'(MAC_LAT - 1));
            a_q         <= tap_step ? img_mem[img_addr] : '0;
            b_q         <= tap_step ? ker_mem[ker_addr] : '0;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mac_en_o    = mac_en_q;
    assign mac_clr_o   = mac_clr_q;
    assign sum_valid_o = sum_valid_q;
    assign a_o         = a_q;
    assign b_o         = b_q;

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Directed bench: feeder driving a behavioural 19-bit MAC, window sums and
// control timing compared against hand-computed values.
module tb_conv_operand_feeder;

    logic       clk = 1'b0, rst = 1'b1;
    logic       load_en = 1'b0, load_sel = 1'b0, start = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       busy, done, mac_en, mac_clr, sum_valid;
    logic [7:0] a, b;
    logic [1:0] out_row, out_col;
    logic [18:0] acc;

    int n_tests = 0, n_fail = 0;
    int got_sum[$], got_row[$], got_col[$];
    int tr_a[$], tr_b[$], tr_c[$];
    int cyc = 0;
    logic clr_prev = 1'b0, clr_before = 1'b0;
    int ramp[9] = '{44, 54, 64, 84, 94, 104, 124, 134, 144};
    int e142[9], s255[9];

    always #5 clk = ~clk;

    conv_operand_feeder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_en_i   (load_en),
        .load_sel_i  (load_sel),
        .load_addr_i (load_addr),
        .load_data_i (load_data),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .a_o         (a),
        .b_o         (b),
        .mac_en_o    (mac_en),
        .mac_clr_o   (mac_clr),
        .sum_valid_o (sum_valid),
        .out_row_o   (out_row),
        .out_col_o   (out_col)
    );

    // Behavioural MAC: clear wins, otherwise accumulate a*b; muxer shows acc.
    always @(posedge clk) begin
        if (rst || mac_clr) acc <= '0;
        else if (mac_en)    acc <= acc + 19'(a) * 19'(b);
    end

    always @(negedge clk) begin
        cyc++;
        if (mac_en === 1'b1) begin
            tr_a.push_back(int'(a));
            tr_b.push_back(int'(b));
            tr_c.push_back(cyc);
            if (tr_a.size() == 1) clr_before = clr_prev;
        end
        clr_prev = mac_clr;
        if (sum_valid === 1'b1) begin
            got_sum.push_back(int'(acc));
            got_row.push_back(int'(out_row));
            got_col.push_back(int'(out_col));
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input bit sel, input int addr, input int data);
        load_en = 1'b1; load_sel = sel; load_addr = 4'(addr); load_data = 8'(data);
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input int exp[9], input bit poke,
                             input bit ld_now, input int ld_addr, input int ld_data);
        int n;
        bit seen;
        got_sum.delete(); got_row.delete(); got_col.delete();
        start = 1'b1;
        if (ld_now) begin
            load_en = 1'b1; load_sel = 1'b0; load_addr = 4'(ld_addr); load_data = 8'(ld_data);
        end
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (n == 1) check({tag, " busy_first"}, busy, 1);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
                if (poke && n == 10) begin
                    start = 1'b1; load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = 8'd99;
                end
                if (poke && n == 11) begin
                    start = 1'b0; load_en = 1'b0;
                end
            end
        end
        check({tag, " done_cycle"}, n, 55);
        check({tag, " done_busy"}, busy, 0);
        check({tag, " n_valid"}, got_sum.size(), 9);
        for (int i = 0; i < 9 && i < got_sum.size(); i++) begin
            check($sformatf("%s sum%0d", tag, i), got_sum[i], exp[i]);
            check($sformatf("%s row%0d", tag, i), got_row[i], i / 3);
            check($sformatf("%s col%0d", tag, i), got_col[i], i % 3);
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 9; i++) begin
            e142[i] = ramp[i];
            s255[i] = 260100;
        end
        e142[0] = 142;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outs", {busy, done, mac_en, mac_clr, sum_valid, a, b, out_row, out_col}, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) load(1'b0, i, i + 1);
        for (int i = 0; i < 4; i++)  load(1'b1, i, i + 1);
        tr_a.delete(); tr_b.delete(); tr_c.delete();

        run_sweep("ramp", ramp, 1'b0, 1'b0, 0, 0);
        check("trace_n", tr_a.size(), 36);
        check("trace_clr_before", clr_before, 1);
        if (tr_a.size() >= 4) begin
            check("trace_a0", tr_a[0], 1); check("trace_b0", tr_b[0], 1);
            check("trace_a1", tr_a[1], 2); check("trace_b1", tr_b[1], 2);
            check("trace_a2", tr_a[2], 5); check("trace_b2", tr_b[2], 3);
            check("trace_a3", tr_a[3], 6); check("trace_b3", tr_b[3], 4);
            check("trace_consec", tr_c[3] - tr_c[0], 3);
        end

        // Start lands in the done cycle of the previous sweep.
        run_sweep("b2b", ramp, 1'b0, 1'b0, 0, 0);
        run_sweep("ignore_busy", ramp, 1'b1, 1'b0, 0, 0);

        load(1'b0, 0, 99);
        run_sweep("pix99", e142, 1'b0, 1'b0, 0, 0);

        run_sweep("load_with_start", ramp, 1'b0, 1'b1, 0, 1);

        load(1'b1, 4, 77);
        run_sweep("ker_oor", ramp, 1'b0, 1'b0, 0, 0);

        // Reset during the second FEED cycle of window (1,1) at cycle 27.
        got_sum.delete(); got_row.delete(); got_col.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (26) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_pre_en", mac_en, 1);
        check("rst_pre_rc", {out_row, out_col}, 4'b0101);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_outs", {busy, done, mac_en, mac_clr, sum_valid, a, b, out_row, out_col}, 0);
        check("rst_n_sums", got_sum.size(), 4);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || sum_valid) seen = 1'b1;
        end
        check("rst_quiet", seen, 0);
        run_sweep("after_rst", ramp, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 16; i++) load(1'b0, i, 255);
        for (int i = 0; i < 4; i++)  load(1'b1, i, 255);
        run_sweep("max", s255, 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
